// File: rtl/mp3dec_pkg.sv
// Shared definitions for the MP3 decode sequencer: state encodings and
// default timing constants.
package mp3dec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESET    = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_PRIME    = 3'd3,
        ST_RUN      = 3'd4,
        ST_STALL    = 3'd5,
        ST_DRAIN    = 3'd6,
        ST_ERROR    = 3'd7
    } seq_state_e;

    localparam int unsigned RST_CYCLES_DEF   = 16;
    localparam int unsigned QUIET_CYCLES_DEF = 64;

endpackage

// File: rtl/mp3dec_seq_ctrl.sv
// MP3 decode stream sequencer: reset/prime/run/drain control with FIFO gating.
// Optional RUN watchdog enabled by defining MP3DEC_SEQ_TIMEOUT_EN.
module mp3dec_seq_ctrl
    import mp3dec_pkg::*;
#(
    parameter int LVL_W        = 10,
    parameter int RST_CYCLES   = RST_CYCLES_DEF,
    parameter int QUIET_CYCLES = QUIET_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic             eos,
    input  logic [LVL_W-1:0] prime_lvl,
    input  logic [LVL_W-1:0] low_lvl,
    input  logic [LVL_W-1:0] ififo_lvl,
    input  logic [LVL_W-1:0] ofifo_lvl,
    input  logic             fifo_rst_busy,
    input  logic             ofifo_wr,
    output logic             fifo_rst,
    output logic             dec_rst,
    output logic             dec_en,
    output logic [2:0]       state,
    output logic             busy,
    output logic             evt_underrun,
    output logic             evt_done,
    output logic             evt_timeout
);

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_RESET    = ST_RESET;
    localparam logic [2:0] S_WAIT_RDY = ST_WAIT_RDY;
    localparam logic [2:0] S_PRIME    = ST_PRIME;
    localparam logic [2:0] S_RUN      = ST_RUN;
    localparam logic [2:0] S_STALL    = ST_STALL;
    localparam logic [2:0] S_DRAIN    = ST_DRAIN;
    localparam logic [2:0] S_ERROR    = ST_ERROR;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] QUIET_C  = CNT_W'(QUIET_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             fifo_rst_q, fifo_rst_d;
    logic             dec_rst_q, dec_rst_d;
    logic             dec_en_q, dec_en_d;
    logic             busy_q, busy_d;
    logic             underrun_q, underrun_d;
    logic             done_q, done_d;
    logic             timeout_d;
    logic             lvl_ok;

    // PRIME and STALL share the same release condition.
    assign lvl_ok  = (ififo_lvl >= prime_lvl) || eos;
    assign cnt_inc = sat_inc(cnt_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        underrun_d = 1'b0;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                end
            end
            S_RESET: begin
                cnt_d = cnt_inc;
                if (cnt_q == RST_LAST) state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (!fifo_rst_busy) state_d = S_PRIME;
            end
            S_PRIME: begin
                if (lvl_ok) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (eos && (ififo_lvl == '0)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else if (ififo_lvl < low_lvl) begin
                    state_d    = S_STALL;
                    underrun_d = 1'b1;
                end
`ifdef MP3DEC_SEQ_TIMEOUT_EN
                else begin
                    cnt_d = ofifo_wr ? '0 : cnt_inc;
                    if (!ofifo_wr && (cnt_inc == CNT_MAX)) begin
                        state_d   = S_ERROR;
                        timeout_d = 1'b1;
                    end
                end
`endif
            end
            S_STALL: begin
                if (lvl_ok) state_d = S_RUN;
            end
            S_DRAIN: begin
                cnt_d = ofifo_wr ? '0 : cnt_inc;
                // Counter value is the number of consecutive write-free cycles seen.
                if (!ofifo_wr && (cnt_inc >= QUIET_C) && (ofifo_lvl == '0)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_ERROR: begin
                if (cmd_start) begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides every other transition and suppresses event pulses.
        if (cmd_stop && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            underrun_d = 1'b0;
            done_d     = 1'b0;
            timeout_d  = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they register with the transition.
    always_comb begin
        fifo_rst_d = (state_d == S_RESET);
        dec_rst_d  = (state_d == S_IDLE) || (state_d == S_RESET) ||
                     (state_d == S_WAIT_RDY) || (state_d == S_ERROR);
        dec_en_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            fifo_rst_q <= 1'b0;
            dec_rst_q  <= 1'b1;
            dec_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fifo_rst_q <= fifo_rst_d;
            dec_rst_q  <= dec_rst_d;
            dec_en_q   <= dec_en_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            done_q     <= done_d;
        end
    end

`ifdef MP3DEC_SEQ_TIMEOUT_EN
    logic timeout_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign evt_timeout = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = timeout_d;
    assign evt_timeout    = 1'b0;
`endif

    assign state        = state_q;
    assign fifo_rst     = fifo_rst_q;
    assign dec_rst      = dec_rst_q;
    assign dec_en       = dec_en_q;
    assign busy         = busy_q;
    assign evt_underrun = underrun_q;
    assign evt_done     = done_q;

endmodule

// File: tb/tb_mp3dec_seq_ctrl.sv
// Scoreboard bench for mp3dec_seq_ctrl: expected output vectors are queued
// as stimulus is applied and compared after the following clock edge.
module tb_mp3dec_seq_ctrl;

    localparam int LVL_W = 10;
    localparam int CNT_W = 8;

    localparam logic [2:0] T_IDLE  = 3'd0;
    localparam logic [2:0] T_RESET = 3'd1;
    localparam logic [2:0] T_WAIT  = 3'd2;
    localparam logic [2:0] T_PRIME = 3'd3;
    localparam logic [2:0] T_RUN   = 3'd4;
    localparam logic [2:0] T_STALL = 3'd5;
    localparam logic [2:0] T_DRAIN = 3'd6;
    localparam logic [2:0] T_ERROR = 3'd7;

`ifdef MP3DEC_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             Clk;
    logic             Rst;
    logic             cmd_start, cmd_stop, eos;
    logic [LVL_W-1:0] prime_lvl, low_lvl, ififo_lvl, ofifo_lvl;
    logic             fifo_rst_busy, ofifo_wr;
    logic             fifo_rst, dec_rst, dec_en, busy;
    logic [2:0]       state;
    logic             evt_underrun, evt_done, evt_timeout;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];

    mp3dec_seq_ctrl #(
        .LVL_W(LVL_W), .RST_CYCLES(16), .QUIET_CYCLES(64), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .eos(eos),
        .prime_lvl(prime_lvl), .low_lvl(low_lvl),
        .ififo_lvl(ififo_lvl), .ofifo_lvl(ofifo_lvl),
        .fifo_rst_busy(fifo_rst_busy), .ofifo_wr(ofifo_wr),
        .fifo_rst(fifo_rst), .dec_rst(dec_rst), .dec_en(dec_en),
        .state(state), .busy(busy),
        .evt_underrun(evt_underrun), .evt_done(evt_done), .evt_timeout(evt_timeout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected output vector for a state, from the per-state output table.
    function automatic logic [9:0] exp_v(input logic [2:0] st, input logic evu,
                                         input logic evd, input logic evt);
        logic fr, dr, en, bz;
        fr = (st == T_RESET);
        dr = (st == T_IDLE) || (st == T_RESET) || (st == T_WAIT) || (st == T_ERROR);
        en = (st == T_RUN) || (st == T_DRAIN);
        bz = (st != T_IDLE);
        return {st, fr, dr, en, bz, evu, evd, evt};
    endfunction

    function automatic logic [9:0] obs();
        return {state, fifo_rst, dec_rst, dec_en, busy, evt_underrun, evt_done, evt_timeout};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_to_prime();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        repeat (17) tick();
    endtask

    task automatic test_reset();
        logic [9:0] e;
        Rst = 1'b1;
        repeat (2) tick();
        exp_q.push_back(exp_v(T_IDLE, 1'b0, 1'b0, 1'b0));
        e = exp_q.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL reset_in: got=%b want=%b", obs(), e); end
        #2 Rst = 1'b0;
        exp_q.push_back(exp_v(T_IDLE, 1'b0, 1'b0, 1'b0));
        tick();
        e = exp_q.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL reset_out: got=%b want=%b", obs(), e); end
    endtask

    task automatic test_start();
        logic [9:0] e;
        logic run;
        int lvl;
        prime_lvl = 10'd64; low_lvl = 10'd8; ififo_lvl = '0; fifo_rst_busy = 1'b1;
        cmd_start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            exp_q.push_back(exp_v((c <= 16) ? T_RESET : T_WAIT, 1'b0, 1'b0, 1'b0));
            tick();
            cmd_start = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin bad++; $display("FAIL start_c%0d: got=%b want=%b", c, obs(), e); end
        end
        fifo_rst_busy = 1'b0;
        exp_q.push_back(exp_v(T_PRIME, 1'b0, 1'b0, 1'b0));
        tick();
        e = exp_q.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL dec_rst_fall: got=%b want=%b", obs(), e); end
        run = 1'b0;
        for (int i = 0; i < 7; i++) begin
            lvl = (i == 6) ? 100 : 16 * i;
            ififo_lvl = 10'(lvl);
            if (lvl >= 64) run = 1'b1;
            exp_q.push_back(exp_v(run ? T_RUN : T_PRIME, 1'b0, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin bad++; $display("FAIL prime_lvl%0d: got=%b want=%b", lvl, obs(), e); end
        end
    endtask

    task automatic test_underrun();
        logic [9:0] e;
        int lvls[7] = '{7, 7, 7, 63, 64, 64, 9};
        logic [2:0] sts[7] = '{T_STALL, T_STALL, T_STALL, T_STALL, T_RUN, T_RUN, T_RUN};
        for (int i = 0; i < 7; i++) begin
            ififo_lvl = 10'(lvls[i]);
            exp_q.push_back(exp_v(sts[i], (i == 0), 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin bad++; $display("FAIL underrun_s%0d: got=%b want=%b", i, obs(), e); end
        end
    endtask

    task automatic test_eos();
        logic [9:0] e;
        eos = 1'b1; ififo_lvl = '0;
        exp_q.push_back(exp_v(T_DRAIN, 1'b0, 1'b0, 1'b0));
        tick();
        e = exp_q.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL eos_enter: got=%b want=%b", obs(), e); end
        ofifo_wr = 1'b1; ofifo_lvl = 10'd20;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(exp_v(T_DRAIN, 1'b0, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin bad++; $display("FAIL drain_wr%0d: got=%b want=%b", i, obs(), e); end
        end
        ofifo_wr = 1'b0;
        for (int k = 1; k <= 65; k++) begin
            ofifo_lvl = (k < 10) ? 10'(20 - 2 * k) : '0;
            if (k == 64) exp_q.push_back(exp_v(T_IDLE, 1'b0, 1'b1, 1'b0));
            else if (k == 65) exp_q.push_back(exp_v(T_IDLE, 1'b0, 1'b0, 1'b0));
            else exp_q.push_back(exp_v(T_DRAIN, 1'b0, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin bad++; $display("FAIL drain_quiet%0d: got=%b want=%b", k, obs(), e); end
        end
        eos = 1'b0;
    endtask

    task automatic test_abort();
        logic [9:0] e;
        prime_lvl = 10'd64; ififo_lvl = '0;
        start_to_prime();
        exp_q.push_back(exp_v(T_PRIME, 1'b0, 1'b0, 1'b0));
        e = exp_q.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL abort_prime: got=%b want=%b", obs(), e); end
        cmd_start = 1'b1;
        exp_q.push_back(exp_v(T_PRIME, 1'b0, 1'b0, 1'b0));
        tick();
        e = exp_q.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL start_ignored: got=%b want=%b", obs(), e); end
        cmd_stop = 1'b1;
        exp_q.push_back(exp_v(T_IDLE, 1'b0, 1'b0, 1'b0));
        tick();
        cmd_start = 1'b0; cmd_stop = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL stop_wins: got=%b want=%b", obs(), e); end
        exp_q.push_back(exp_v(T_IDLE, 1'b0, 1'b0, 1'b0));
        tick();
        e = exp_q.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL abort_hold: got=%b want=%b", obs(), e); end
    endtask

    task automatic test_zero_thresh_rst();
        logic [9:0] e;
        prime_lvl = '0; low_lvl = '0; ififo_lvl = '0;
        start_to_prime();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(exp_v(T_RUN, 1'b0, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin bad++; $display("FAIL zero_thr%0d: got=%b want=%b", i, obs(), e); end
        end
        @(posedge Clk);
        #3 Rst = 1'b1;
        #1;
        exp_q.push_back(exp_v(T_IDLE, 1'b0, 1'b0, 1'b0));
        e = exp_q.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL rst_async: got=%b want=%b", obs(), e); end
        @(posedge Clk);
        #3 Rst = 1'b0;
        exp_q.push_back(exp_v(T_IDLE, 1'b0, 1'b0, 1'b0));
        tick();
        e = exp_q.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL rst_release: got=%b want=%b", obs(), e); end
    endtask

    task automatic test_timeout();
        logic [9:0] e;
        prime_lvl = 10'd64; low_lvl = 10'd8; ififo_lvl = '0;
        start_to_prime();
        ififo_lvl = 10'd100;
        exp_q.push_back(exp_v(T_RUN, 1'b0, 1'b0, 1'b0));
        tick();
        e = exp_q.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL to_run: got=%b want=%b", obs(), e); end
        for (int k = 1; k <= 258; k++) begin
            if (TO_EN && (k == 255)) exp_q.push_back(exp_v(T_ERROR, 1'b0, 1'b0, 1'b1));
            else if (TO_EN && (k > 255)) exp_q.push_back(exp_v(T_ERROR, 1'b0, 1'b0, 1'b0));
            else exp_q.push_back(exp_v(T_RUN, 1'b0, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin bad++; $display("FAIL to_k%0d: got=%b want=%b", k, obs(), e); end
        end
        cmd_start = 1'b1;
        exp_q.push_back(exp_v(TO_EN ? T_RESET : T_RUN, 1'b0, 1'b0, 1'b0));
        tick();
        cmd_start = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL to_restart: got=%b want=%b", obs(), e); end
        cmd_stop = 1'b1;
        exp_q.push_back(exp_v(T_IDLE, 1'b0, 1'b0, 1'b0));
        tick();
        cmd_stop = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL to_stop: got=%b want=%b", obs(), e); end
    endtask

    initial begin
        Rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; eos = 1'b0;
        prime_lvl = '0; low_lvl = '0; ififo_lvl = '0; ofifo_lvl = '0;
        fifo_rst_busy = 1'b0; ofifo_wr = 1'b0;
        test_reset();
        test_start();
        test_underrun();
        test_eos();
        test_abort();
        test_zero_thresh_rst();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mp3dec_seq_ctrl.md
# mp3dec_seq_ctrl

Sequencer for the MP3 decode datapath. It runs one clock domain alongside the decoder core. It owns the decoder reset/enable and the shared FIFO reset, and it brings a stream up in order: reset, FIFO settle, input priming, run. While running it gates the decoder on input-FIFO level, drains the output at end of stream, and reports progress events to the interrupt logic.

## Interface
- LVL_W, 10, width of FIFO level and threshold buses
- RST_CYCLES, 16, cycles `fifo_rst` is held high during a reset sequence (≥1)
- QUIET_CYCLES, 64, idle-output cycles required before DRAIN completes (≥1, < 2^CNT_W)
- CNT_W, 16, width of the shared sequence counter
- Clk  in  1  clock (the decoder clock)
- Rst  in  1  asynchronous, active-high reset
- cmd_start  in  1  single-cycle start request
- cmd_stop  in  1  single-cycle abort request
- eos  in  1  level; the host has written the final input word
- prime_lvl  in  LVL_W  input level needed to (re)enter RUN
- low_lvl  in  LVL_W  input level below which RUN stalls
- ififo_lvl  in  LVL_W  input FIFO read-side word count
- ofifo_lvl  in  LVL_W  output FIFO write-side word count
- fifo_rst_busy  in  1  OR of both FIFOs' reset-busy flags
- ofifo_wr  in  1  decoder PCM write strobe
- fifo_rst  out  1  FIFO reset
- dec_rst  out  1  decoder reset (active-high)
- dec_en  out  1  decoder enable
- state  out  3  current state encoding
- busy  out  1  high in every state except IDLE
- evt_underrun  out  1  one-cycle pulse on RUN→STALL
- evt_done  out  1  one-cycle pulse on DRAIN→IDLE
- evt_timeout  out  1  one-cycle pulse on RUN→ERROR

## Operation
- States and encodings: IDLE=0, RESET=1, WAIT_RDY=2, PRIME=3, RUN=4, STALL=5, DRAIN=6, ERROR=7.
- **IDLE**: `dec_rst`=1, `dec_en`=0, `fifo_rst`=0. On `cmd_start`, go to RESET and clear the counter.
- **RESET**: `fifo_rst`=1, `dec_rst`=1. The counter increments. After RST_CYCLES cycles, go to WAIT_RDY with `fifo_rst`=0.
- **WAIT_RDY**: `dec_rst`=1. When `fifo_rst_busy`=0, go to PRIME with `dec_rst`=0.
- **PRIME**: `dec_en`=0. If `ififo_lvl`≥`prime_lvl` or `eos`, go to RUN.
- **RUN**: `dec_en`=1.
  - If `eos` and `ififo_lvl`==0, go to DRAIN and clear the counter.
  - Otherwise, if `ififo_lvl`<`low_lvl`, go to STALL and pulse `evt_underrun`.
- **STALL**: `dec_en`=0. If `ififo_lvl`≥`prime_lvl` or `eos`, go to RUN.
- **DRAIN**: `dec_en`=1.
  - The counter clears on `ofifo_wr` and increments otherwise.
  - When the counter reaches QUIET_CYCLES and `ofifo_lvl`==0, go to IDLE and pulse `evt_done`.
- **ERROR**: `dec_en`=0, `dec_rst`=1. `cmd_start` goes to RESET.
- `cmd_stop` in any non-IDLE state goes to IDLE. It wins over `cmd_start` and over all other transitions in the same cycle.
- `cmd_start` outside IDLE and ERROR is ignored.
- All comparisons are unsigned at LVL_W bits.
  - `prime_lvl`=0 makes PRIME and STALL exit on the next cycle.
  - `low_lvl`=0 disables stalling.
- The counter saturates at 2^CNT_W−1 and never wraps.

## Timing
- All outputs are registered. Reset values: `state`=0, `dec_rst`=1, `dec_en`=0, `fifo_rst`=0, `busy`=0, all `evt_*`=0.
- `Rst` asserted mid-sequence forces the reset values immediately, asynchronously.
- Every output reflects a transition one cycle after the triggering input is sampled.
- Start sequence:
  - `cmd_start` sampled at cycle 0.
  - `fifo_rst` is high for cycles 1…RST_CYCLES.
  - WAIT_RDY is entered at cycle RST_CYCLES+1.
  - `dec_rst` falls on the cycle after `fifo_rst_busy` is first sampled low.
- Threshold crossings move `dec_en` with 1-cycle latency.

## Configuration
- `MP3DEC_SEQ_TIMEOUT_EN` defined:
  - In RUN, the counter clears on `ofifo_wr` and increments otherwise.
  - At 2^CNT_W−1 the block goes to ERROR and pulses `evt_timeout`.
  - Counting pauses while in STALL; the count resumes from its held value.
- Undefined: ERROR is unreachable, `evt_timeout` is tied 0, and the port is retained.

## Structure
- Shared package `mp3dec_pkg` holds:
  - the state enum with the encodings above,
  - default RST_CYCLES and QUIET_CYCLES constants.
- No sub-module. The single shared counter and the FSM live in one module.

## Test plan
- Start sequence: RST_CYCLES=16, `fifo_rst_busy` falls 5 cycles after `fifo_rst` falls, `prime_lvl`=64, `ififo_lvl` ramps 0→100 → `fifo_rst` high exactly 16 cycles; `dec_rst` falls 1 cycle after busy falls; `dec_en` rises 1 cycle after `ififo_lvl` reaches 64.
- Underrun/resume: in RUN with `low_lvl`=8, `prime_lvl`=64, drop `ififo_lvl` to 7 → `evt_underrun` single pulse, `dec_en`=0; raise it to 64 → `dec_en`=1 one cycle later.
- End of stream: `eos`=1, `ififo_lvl`=0, then `ofifo_wr` pulses for 10 cycles and `ofifo_lvl` decays to 0 → DRAIN; `evt_done` and IDLE exactly QUIET_CYCLES=64 cycles after the last `ofifo_wr`.
- Abort: `cmd_stop` and `cmd_start` together during PRIME → IDLE next cycle, `dec_rst`=1, `dec_en`=0, `busy`=0.
- Reset mid-RUN: assert `Rst` between clock edges → all outputs take reset values before the next edge.
- With `MP3DEC_SEQ_TIMEOUT_EN` and CNT_W=8: RUN with no `ofifo_wr` for 255 cycles → ERROR and `evt_timeout`; then `cmd_start` → RESET. Without the macro, the same stimulus keeps the block in RUN.
